// File: rtl/frame_sched_pkg.sv
//------------------------------------------------------------------------------
// Module      : frame_sched_pkg
// Description : Shared types and default sizes for the frame scheduler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package frame_sched_pkg;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_SKIP_W  = 4;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SKIP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [23:0] pixel;
        logic        hsync;
        logic        vsync;
        logic        vde;
    } video_t;

endpackage

`default_nettype wire

// File: rtl/frame_sched_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : rr_arbiter
// Description : Round-robin one-hot pick starting after the last granted index.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import frame_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] hi_idx;
    logic [PTR_W-1:0] lo_idx;
    logic [PTR_W-1:0] pick_idx;
    logic             hi_found;
    logic             lo_found;

    // Descending scan: the lowest requester above the pointer wins, else the
    // lowest requester overall (wrap-around).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = PTR_W'(i);
                if (PTR_W'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(i);
                end
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
        valid    = lo_found;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = lo_found && (pick_idx == PTR_W'(i));
        end
        ptr_d = (advance && lo_found) ? pick_idx : ptr_q;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_sched.sv
//------------------------------------------------------------------------------
// Module      : frame_sched
// Description : Grants whole video frames round-robin to consumers, skipping a
//               programmable number of frames between grants; gates sync lines.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int SKIP_W  = DEF_SKIP_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               en,
    input  logic [SKIP_W-1:0]  num_skip,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic [CNT_W-1:0]   frame_cnt,
    input  logic [23:0]        pixel_data_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               vde_in,
    output logic [23:0]        pixel_data_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               vde_out
);

    state_e             state_q,     state_d;
    logic [SKIP_W-1:0]  skip_cnt_q,  skip_cnt_d;
    logic [SKIP_W-1:0]  skip_lat_q,  skip_lat_d;
    logic [NUM_REQ-1:0] grant_q,     grant_d;
    logic [NUM_REQ-1:0] done_q,      done_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               vsync_q,     vsync_d;
    logic               armed_q,     armed_d;
    video_t             vid_q,       vid_d;

    logic               sof;
    logic               do_arb;
    logic               advance;
    logic               active_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .arst    (arst),
        .req     (req),
        .advance (advance),
        .gnt     (arb_gnt),
        .valid   (arb_valid)
    );

    // armed_q blocks a false sof when vsync is already high at reset release.
    always_comb begin
        vsync_d     = vsync_in;
        armed_d     = armed_q | ~vsync_in;
        sof         = vsync_in & ~vsync_q & armed_q;

        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        skip_lat_d  = skip_lat_q;
        grant_d     = grant_q;
        done_d      = '0;
        frame_cnt_d = frame_cnt_q;
        advance     = 1'b0;
        do_arb      = 1'b0;

        if (sof) begin
            case (state_q)
                ST_IDLE: do_arb = 1'b1;
                ST_ACTIVE: begin
                    done_d = grant_q;
                    if (skip_lat_q == '0) begin
                        do_arb = 1'b1;
                    end else begin
                        state_d    = ST_SKIP;
                        skip_cnt_d = skip_lat_q - SKIP_W'(1);
                        grant_d    = '0;
                    end
                end
                ST_SKIP: begin
                    if (skip_cnt_q == '0) begin
                        do_arb = 1'b1;
                    end else begin
                        skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                    end
                end
                default: do_arb = 1'b1;
            endcase
        end

        if (do_arb) begin
            if (en && arb_valid) begin
                state_d     = ST_ACTIVE;
                grant_d     = arb_gnt;
                skip_lat_d  = num_skip;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                advance     = 1'b1;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        end

        // Gate with the next state so a new frame passes from its sof cycle.
        active_d    = (state_d == ST_ACTIVE);
        vid_d.pixel = pixel_data_in;
        vid_d.hsync = hsync_in & active_d;
        vid_d.vsync = vsync_in & active_d;
        vid_d.vde   = vde_in & active_d;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            skip_cnt_q  <= '0;
            skip_lat_q  <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            frame_cnt_q <= '0;
            vsync_q     <= 1'b0;
            armed_q     <= 1'b0;
            vid_q       <= '0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            skip_lat_q  <= skip_lat_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            armed_q     <= armed_d;
            vid_q       <= vid_d;
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign frame_cnt      = frame_cnt_q;
    assign pixel_data_out = vid_q.pixel;
    assign hsync_out      = vid_q.hsync;
    assign vsync_out      = vid_q.vsync;
    assign vde_out        = vid_q.vde;

endmodule

`default_nettype wire

// File: tb/tb_frame_sched.sv
//------------------------------------------------------------------------------
// Module      : tb_frame_sched
// Description : Directed frame-level bench for frame_sched.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frame_sched;

    localparam int NR   = 2;
    localparam int SW   = 4;
    localparam int CW   = 16;
    localparam int FLEN = 16;

    logic          clk = 1'b0;
    logic          arst;
    logic          en;
    logic [SW-1:0] num_skip;
    logic [NR-1:0] req;
    logic [NR-1:0] grant;
    logic [NR-1:0] done;
    logic [CW-1:0] frame_cnt;
    logic [23:0]   pix_in;
    logic [23:0]   pix_out;
    logic          hsync_in, vsync_in, vde_in;
    logic          hsync_out, vsync_out, vde_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_sched #(
        .NUM_REQ (NR),
        .SKIP_W  (SW),
        .CNT_W   (CW)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .en             (en),
        .num_skip       (num_skip),
        .req            (req),
        .grant          (grant),
        .done           (done),
        .frame_cnt      (frame_cnt),
        .pixel_data_in  (pix_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .vde_in         (vde_in),
        .pixel_data_out (pix_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .vde_out        (vde_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of video; optional async reset pulse between edges.
    task automatic step(input logic vs, input logic hs, input logic de,
                        input logic [23:0] px, input bit pulse_rst);
        @(negedge clk);
        vsync_in = vs;
        hsync_in = hs;
        vde_in   = de;
        pix_in   = px;
        if (pulse_rst) begin
            #1 arst = 1'b1;
            #1;
            check("rst_async_grant", 32'(grant), 32'd0);
            check("rst_async_done", 32'(done), 32'd0);
            check("rst_async_sync", {29'd0, vsync_out, hsync_out, vde_out}, 32'd0);
            check("rst_async_cnt", 32'(frame_cnt), 32'd0);
            check("rst_async_pix", 32'(pix_out), 32'd0);
            #1 arst = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst     = 1'b1;
        en       = 1'b1;
        num_skip = '0;
        req      = '0;
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        vde_in   = 1'b0;
        pix_in   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    endtask

    // ev_kind: 1 = drop req[0], 2 = drop en, 3 = reset pulse, at cycle ev_cyc.
    task automatic run_frame(input string tag, input logic [NR-1:0] g_exp,
                             input logic [NR-1:0] d_exp, input int vde_exp,
                             input int ev_cyc, input int ev_kind, input bit chk_gate);
        int            vde_cnt  = 0;
        int            done_cnt = 0;
        int            bad      = 0;
        logic [NR-1:0] g0       = '0;
        logic [NR-1:0] d0       = '0;
        for (int c = 0; c < FLEN; c++) begin
            logic        vs, hs, de, gate;
            logic [23:0] px;
            bit          pr;
            vs = (c < 2);
            hs = ((c % 4) == 3);
            de = (c >= 4) && (c < 14);
            px = 24'($urandom);
            pr = 1'b0;
            if (c == ev_cyc) begin
                case (ev_kind)
                    1:       req[0] = 1'b0;
                    2:       en = 1'b0;
                    3:       pr = 1'b1;
                    default: ;
                endcase
            end
            step(vs, hs, de, px, pr);
            if (c == 0) begin
                g0 = grant;
                d0 = done;
            end
            if (done != '0) done_cnt++;
            if (vde_out) vde_cnt++;
            if (pix_out !== px) bad++;
            if (chk_gate) begin
                gate = (g0 != '0);
                if (grant !== g0) bad++;
                if (vsync_out !== (vs & gate) || hsync_out !== (hs & gate) ||
                    vde_out !== (de & gate)) bad++;
            end
        end
        check({tag, "_grant"}, 32'(g0), 32'(g_exp));
        check({tag, "_done"}, 32'(d0), 32'(d_exp));
        check({tag, "_vde_cnt"}, 32'(vde_cnt), 32'(vde_exp));
        check({tag, "_done_pulses"}, 32'(done_cnt), (d_exp != '0) ? 32'd1 : 32'd0);
        check({tag, "_video"}, 32'(bad), 32'd0);
    endtask

    initial begin
        // T1: single requester, no skip
        do_reset();
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_cnt", 32'(frame_cnt), 32'd0);
        check("reset_sync", {29'd0, vsync_out, hsync_out, vde_out}, 32'd0);
        req = 2'b01;
        run_frame("t1f1", 2'b01, 2'b00, 10, -1, 0, 1'b1);
        run_frame("t1f2", 2'b01, 2'b01, 10, -1, 0, 1'b1);
        run_frame("t1f3", 2'b01, 2'b01, 10, -1, 0, 1'b1);
        check("t1_cnt", 32'(frame_cnt), 32'd3);
        req = 2'b00;
        run_frame("t1f4", 2'b00, 2'b01, 0, -1, 0, 1'b1);
        check("t1_cnt_idle", 32'(frame_cnt), 32'd3);

        // T2: two requesters alternate
        do_reset();
        req = 2'b11;
        run_frame("t2f1", 2'b01, 2'b00, 10, -1, 0, 1'b1);
        run_frame("t2f2", 2'b10, 2'b01, 10, -1, 0, 1'b1);
        run_frame("t2f3", 2'b01, 2'b10, 10, -1, 0, 1'b1);
        run_frame("t2f4", 2'b10, 2'b01, 10, -1, 0, 1'b1);
        check("t2_cnt", 32'(frame_cnt), 32'd4);

        // T3: skip two frames after each grant
        do_reset();
        num_skip = 4'd2;
        req      = 2'b01;
        run_frame("t3f0", 2'b01, 2'b00, 10, -1, 0, 1'b1);
        run_frame("t3f1", 2'b00, 2'b01, 0, -1, 0, 1'b1);
        run_frame("t3f2", 2'b00, 2'b00, 0, -1, 0, 1'b1);
        run_frame("t3f3", 2'b01, 2'b00, 10, -1, 0, 1'b1);
        run_frame("t3f4", 2'b00, 2'b01, 0, -1, 0, 1'b1);
        run_frame("t3f5", 2'b00, 2'b00, 0, -1, 0, 1'b1);
        run_frame("t3f6", 2'b01, 2'b00, 10, -1, 0, 1'b1);
        check("t3_cnt", 32'(frame_cnt), 32'd3);

        // T4: request drops mid-frame
        do_reset();
        req = 2'b01;
        run_frame("t4f0", 2'b01, 2'b00, 10, 6, 1, 1'b1);
        run_frame("t4f1", 2'b00, 2'b01, 0, -1, 0, 1'b1);
        check("t4_cnt", 32'(frame_cnt), 32'd1);

        // T5: enable drops mid-frame, then returns
        do_reset();
        req = 2'b11;
        run_frame("t5f0", 2'b01, 2'b00, 10, -1, 0, 1'b1);
        run_frame("t5f1", 2'b10, 2'b01, 10, 6, 2, 1'b1);
        run_frame("t5f2", 2'b00, 2'b10, 0, -1, 0, 1'b1);
        en = 1'b1;
        run_frame("t5f3", 2'b01, 2'b00, 10, -1, 0, 1'b1);
        check("t5_cnt", 32'(frame_cnt), 32'd3);

        // T6: async reset pulse inside an active frame
        do_reset();
        req = 2'b01;
        run_frame("t6f0", 2'b01, 2'b00, 2, 6, 3, 1'b0);
        run_frame("t6f1", 2'b01, 2'b00, 10, -1, 0, 1'b1);
        check("t6_cnt", 32'(frame_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_sched.md
Name: frame_sched

Overview:
- Frame-granular scheduler between the camera video stream and NUM_REQ downstream consumers, e.g. feature extractor and frame-buffer writer.
- At each start of frame it grants the whole frame to one requesting consumer, chosen round-robin.
- Between grants it skips a programmable number of frames.
- It gates the pass-through sync/enable lines so only granted frames reach downstream logic, and reports frame ownership and completion.

Parameters:
- NUM_REQ, 2, number of frame consumers (2..8).
- SKIP_W, 4, width of num_skip.
- CNT_W, 16, width of granted-frame counter.

Ports:
- clk  in  1  system/pixel clock.
- arst  in  1  asynchronous reset, active-high.
- en  in  1  allow new grants; 0 lets the current frame finish, then stays idle.
- num_skip  in  SKIP_W  frames dropped after each granted frame; sampled at grant.
- req  in  NUM_REQ  per-consumer frame request, level.
- grant  out  NUM_REQ  one-hot owner of current frame, or all-zero; held for the whole frame.
- done  out  NUM_REQ  1-cycle pulse to owner when its frame ends.
- frame_cnt  out  CNT_W  granted frames since reset, wraps.
- pixel_data_in  in  24  RGB pixel.
- hsync_in, vsync_in, vde_in  in  1 each  input timing.
- pixel_data_out  out  24  pixel_data_in delayed 1 cycle, never gated.
- hsync_out, vsync_out, vde_out  out  1 each  input timing delayed 1 cycle, ANDed with frame-granted.

Behaviour:
- Reset values: all outputs 0. State IDLE. skip_cnt=0. rr pointer = NUM_REQ-1, so req[0] wins first.
- Start of frame: sof = vsync_in & ~vsync_q. vsync_q is registered and reset to 0.
- States:
  - IDLE: no owner.
  - ACTIVE: owner valid.
  - SKIP: dropping frames.
- Transitions happen only in a sof cycle; all other cycles hold state.
- "Arbitrate" means:
  - If en and |req: grant the next requester after the last owner, cyclically.
  - Go to ACTIVE, latch num_skip into skip_lat, increment frame_cnt.
  - Otherwise go to IDLE with grant=0.
- Transitions on sof:
  - IDLE: arbitrate.
  - ACTIVE: pulse done[owner] in the next cycle. Then if skip_lat==0, arbitrate in the same sof. Else go to SKIP with skip_cnt=skip_lat-1.
  - SKIP: if skip_cnt==0, arbitrate. Else decrement skip_cnt.
- Gating:
  - Output registers use next-state active.
  - A granted frame's vsync_out is present from its first cycle.
  - The previous owner's frame never leaks into the new frame.
- Latency: video and grant are 1 cycle. done asserts the cycle after sof, together with the new grant.
- A requester deasserting req mid-frame is ignored; its frame completes and done still pulses.
- Same requester re-granted back-to-back: done and grant[i] are both 1 in the same cycle.
- en falling mid-frame: the current frame completes, then IDLE.
- Reset asserted mid-frame: all outputs 0 immediately, asynchronously.
- Reset released mid-frame: outputs stay gated until the next sof, which arbitrates with skip=0.
- vsync_in held high across the release: no sof until a new rising edge.
- rr pointer updates only on a grant.

Decomposition:
- Package frame_sched_pkg:
  - state enum (IDLE, ACTIVE, SKIP).
  - default NUM_REQ/SKIP_W/CNT_W constants.
  - video bus struct {pixel[23:0], hsync, vsync, vde}.
- Sub-module rr_arbiter (NUM_REQ):
  - combinational one-hot pick from req and last-grant pointer.
  - registered pointer update on an advance strobe.

Test Plan:
- Reset, num_skip=0, req=2'b01, 3 frames: grant=01 on all 3, done[0] pulses at sof 2, 3, 4, frame_cnt=3, output syncs equal input delayed 1 cycle.
- req=2'b11, num_skip=0, 4 frames: grant sequence 01,10,01,10; done alternates.
- num_skip=2, req=2'b01, 7 frames: frames 0 and 3 granted, frames 1,2,4,5 gated (vsync_out/vde_out stay 0), frame 6 granted.
- req[0] drops at mid frame 0: vde_out continues to frame end, done[0] pulses, grant=00 after.
- en=0 at mid frame 1 with req=11: frame 1 completes, no grant on frame 2; en=1 restores a grant at sof 3.
- arst pulse mid-line during an ACTIVE frame: outputs 0 that cycle; after release no vde_out until the next sof, then grant=01.
